core101_icache: RTL and testbench
=================================

Name: core101_icache

Overview:
Direct-mapped, one-word-per-line instruction cache between the Core101 fetch port and the main-memory instruction port.
- Hits return the word after 1 cycle.
- Misses issue a single-word req/ack refill to memory, install the line and forward the word.
- Supports a whole-cache flush for fence.i and self-modifying code.

Parameters:
LINES, 16, number of cache lines; power of two, at least 2; IDX_W = log2(LINES)
ADDR_W, 32, byte address width

Ports:
clock_in  input  1  core clock
reset_in  input  1  synchronous active-high reset
core_req_in  input  1  fetch request, sampled only when core_ready_out=1
core_addr_in  input  ADDR_W  fetch byte address; bits [1:0] ignored
core_ready_out  output  1  cache can accept a request this cycle
core_valid_out  output  1  single-cycle pulse, core_data_out valid
core_data_out  output  32  fetched instruction word
core_flush_in  input  1  invalidate all lines
mem_req_out  output  1  refill request, held until ack
mem_addr_out  output  ADDR_W  refill word address, bits [1:0]=0
mem_data_in  input  32  refill data, valid with mem_ack_in
mem_ack_in  input  1  refill complete

Behaviour:
- Address split: index = addr[IDX_W+1:2]; tag = addr[ADDR_W-1:IDX_W+2].
- Storage per line: valid bit, tag, 32-bit data, all in flops.
- Reset, synchronous and active-high on clock_in/reset_in:
  - all valid bits cleared; state IDLE
  - core_valid_out=0, core_data_out=0, mem_req_out=0, mem_addr_out=0
  - tag and data arrays are not reset.
- core_ready_out = (state==IDLE) && !core_flush_in && !reset_in.
- States: IDLE, REFILL, RESP.
- IDLE:
  - On a request, latch the address.
  - Hit (valid && tag match): next cycle core_valid_out=1 and core_data_out=line data; stay IDLE. Back-to-back hits sustain 1 word/cycle.
  - Miss: go to REFILL. Next cycle mem_req_out=1 and mem_addr_out={latched addr[ADDR_W-1:2],2'b00}.
- REFILL:
  - mem_req_out and mem_addr_out held stable until mem_ack_in=1.
  - On ack: write data/tag/valid to the line, capture mem_data_in, drop mem_req_out next cycle, go to RESP.
  - Miss-to-valid latency = 2 + memory wait cycles (ack in the first REFILL cycle gives a 3-cycle miss).
- RESP: core_valid_out=1 with the refilled word for exactly one cycle, then IDLE.
- core_data_out holds its last value when core_valid_out=0.
- mem_ack_in outside REFILL is ignored.
- Flush:
  - core_flush_in=1 clears every valid bit at the next edge, in any state.
  - A request in the same cycle is not accepted, because core_ready_out is 0.
  - Flush during REFILL: the refill completes and the word is delivered to the core, but the line is written invalid.
  - Flush in the same cycle as ack: the flush wins, and the line stays invalid.
- Conflict: a new tag at an occupied index overwrites that line on refill. There is no write path from the core.
- Reset mid-refill: abandons the refill; mem_req_out=0 the next cycle. A late ack after reset is ignored.

Optional Feature:
Macro ICACHE_STATS_EN.
- Defined: adds outputs hit_count_out[31:0] and miss_count_out[31:0].
  - Each increments by 1 on every accepted hit or miss.
  - Both reset to 0 and wrap from 0xFFFFFFFF to 0.
  - Neither is cleared by flush.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
1. Cold miss: after reset, req addr 0x0000_0040; mem ack 2 cycles after mem_req_out rises, data 0x00500093 -> mem_addr_out=0x40 held until ack; core_valid_out pulses once with 0x00500093; core_ready_out low throughout.
2. Hit: repeat req 0x40 -> core_valid_out the next cycle, data 0x00500093, no mem_req_out. Hits at 0x40 and 0x44, both pre-filled, on back-to-back cycles -> two consecutive valid pulses.
3. Conflict: LINES=16; fill 0x40, then req 0x80 (same index 0, different tag) -> miss and refill. A following req 0x40 -> miss again.
4. Flush during refill: miss on 0x100; assert core_flush_in before ack -> word still delivered; next req 0x100 misses. Flush coincident with ack -> same result.
5. Reset mid-refill: miss on 0x200, reset in REFILL -> mem_req_out=0 and core_valid_out=0 the next cycle; a stray ack is ignored; req 0x200 misses.
6. ICACHE_STATS_EN: 3 misses and 5 hits -> miss_count_out=3, hit_count_out=5. After flush, counts unchanged; after reset, both 0.

Source files
------------

// File: rtl/core101_icache.sv
// Core101 direct-mapped, one-word-per-line instruction cache with req/ack refill and whole-cache flush.
// Optional hit/miss counters are enabled by defining ICACHE_STATS_EN.
module core101_icache #(
    parameter int unsigned LINES  = 16,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clock_in,
    input  logic              reset_in,
    input  logic              core_req_in,
    input  logic [ADDR_W-1:0] core_addr_in,
    output logic              core_ready_out,
    output logic              core_valid_out,
    output logic [31:0]       core_data_out,
    input  logic              core_flush_in,
    output logic              mem_req_out,
    output logic [ADDR_W-1:0] mem_addr_out,
    input  logic [31:0]       mem_data_in,
    input  logic              mem_ack_in
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]       hit_count_out,
    output logic [31:0]       miss_count_out
`endif
);

    localparam int unsigned IDX_W   = $clog2(LINES);
    localparam int unsigned WADDR_W = ADDR_W - 2;
    localparam int unsigned TAG_W   = ADDR_W - IDX_W - 2;
    localparam int unsigned DATA_W  = 32;

    typedef enum logic [1:0] {
        IDLE,
        REFILL,
        RESP
    } state_t;

    state_t              state_q;
    state_t              state_d;

    logic [LINES-1:0]    valid_q;
    logic [TAG_W-1:0]    tag_q  [LINES];
    logic [DATA_W-1:0]   data_q [LINES];

    logic [WADDR_W-1:0]  waddr_q;
    logic [WADDR_W-1:0]  waddr_d;
    logic [DATA_W-1:0]   fill_data_q;
    logic [DATA_W-1:0]   fill_data_d;
    logic                flushed_q;
    logic                flushed_d;

    logic                core_valid_d;
    logic [DATA_W-1:0]   core_data_d;
    logic                mem_req_d;
    logic [ADDR_W-1:0]   mem_addr_d;

    logic [IDX_W-1:0]    req_idx;
    logic [TAG_W-1:0]    req_tag;
    logic [IDX_W-1:0]    fill_idx;
    logic [TAG_W-1:0]    fill_tag;
    logic                lookup_hit;
    logic                accept;
    logic                fill_we;
    logic                unused_addr_bits;

    // Byte-offset bits of the fetch address carry no information for a word cache.
    assign unused_addr_bits = ^core_addr_in[1:0];

    assign req_idx    = core_addr_in[IDX_W+1:2];
    assign req_tag    = core_addr_in[ADDR_W-1:IDX_W+2];
    assign fill_idx   = waddr_q[IDX_W-1:0];
    assign fill_tag   = waddr_q[WADDR_W-1:IDX_W];
    assign lookup_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

    assign core_ready_out = (state_q == IDLE) && !core_flush_in && !reset_in;
    assign accept         = core_req_in && core_ready_out;
    assign fill_we        = (state_q == REFILL) && mem_ack_in && !reset_in;

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state_q;
        waddr_d      = waddr_q;
        fill_data_d  = fill_data_q;
        flushed_d    = flushed_q;
        core_valid_d = 1'b0;
        core_data_d  = core_data_out;
        mem_req_d    = mem_req_out;
        mem_addr_d   = mem_addr_out;

        case (state_q)
            IDLE: begin
                flushed_d = 1'b0;
                if (accept) begin
                    waddr_d = core_addr_in[ADDR_W-1:2];
                    if (lookup_hit) begin
                        core_valid_d = 1'b1;
                        core_data_d  = data_q[req_idx];
                    end else begin
                        state_d    = REFILL;
                        mem_req_d  = 1'b1;
                        mem_addr_d = {core_addr_in[ADDR_W-1:2], 2'b00};
                    end
                end
            end
            REFILL: begin
                // A flush seen while the refill is outstanding must leave the line invalid.
                if (core_flush_in) begin
                    flushed_d = 1'b1;
                end
                if (mem_ack_in) begin
                    state_d     = RESP;
                    mem_req_d   = 1'b0;
                    fill_data_d = mem_data_in;
                end
            end
            RESP: begin
                state_d      = IDLE;
                core_valid_d = 1'b1;
                core_data_d  = fill_data_q;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state_q        <= IDLE;
            waddr_q        <= '0;
            fill_data_q    <= '0;
            flushed_q      <= 1'b0;
            core_valid_out <= 1'b0;
            core_data_out  <= '0;
            mem_req_out    <= 1'b0;
            mem_addr_out   <= '0;
        end else begin
            state_q        <= state_d;
            waddr_q        <= waddr_d;
            fill_data_q    <= fill_data_d;
            flushed_q      <= flushed_d;
            core_valid_out <= core_valid_d;
            core_data_out  <= core_data_d;
            mem_req_out    <= mem_req_d;
            mem_addr_out   <= mem_addr_d;
        end
    end

    // Valid bits: reset and flush take priority over a completing refill.
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            valid_q <= '0;
        end else if (core_flush_in) begin
            valid_q <= '0;
        end else if (fill_we && !flushed_q) begin
            valid_q[fill_idx] <= 1'b1;
        end
    end

    // Tag and data arrays carry no reset.
    always_ff @(posedge clock_in) begin
        if (fill_we) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= mem_data_in;
        end
    end

`ifdef ICACHE_STATS_EN
    // Free-running hit/miss counters; only reset clears them.
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            hit_count_out  <= '0;
            miss_count_out <= '0;
        end else if (accept) begin
            if (lookup_hit) begin
                hit_count_out <= hit_count_out + 32'd1;
            end else begin
                miss_count_out <= miss_count_out + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_core101_icache.sv
// Directed bench for core101_icache: cycle-by-cycle vector table plus hand-written multi-cycle sequences.
module tb_core101_icache;

    logic        clock_in;
    logic        reset_in;
    logic        core_req_in;
    logic [31:0] core_addr_in;
    logic        core_ready_out;
    logic        core_valid_out;
    logic [31:0] core_data_out;
    logic        core_flush_in;
    logic        mem_req_out;
    logic [31:0] mem_addr_out;
    logic [31:0] mem_data_in;
    logic        mem_ack_in;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count_out;
    logic [31:0] miss_count_out;
`endif

    core101_icache #(.LINES(16), .ADDR_W(32)) dut (
        .clock_in       (clock_in),
        .reset_in       (reset_in),
        .core_req_in    (core_req_in),
        .core_addr_in   (core_addr_in),
        .core_ready_out (core_ready_out),
        .core_valid_out (core_valid_out),
        .core_data_out  (core_data_out),
        .core_flush_in  (core_flush_in),
        .mem_req_out    (mem_req_out),
        .mem_addr_out   (mem_addr_out),
        .mem_data_in    (mem_data_in),
        .mem_ack_in     (mem_ack_in)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count_out  (hit_count_out),
        .miss_count_out (miss_count_out)
`endif
    );

    initial clock_in = 1'b0;
    always #5 clock_in = ~clock_in;

    typedef struct {
        logic        rst;
        logic        req;
        logic [31:0] addr;
        logic        flush;
        logic        ack;
        logic [31:0] mdata;
        logic        e_rdy;
        logic        e_val;
        logic [31:0] e_data;
        logic        e_mreq;
        logic [31:0] e_maddr;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic req, input logic [31:0] addr,
                       input logic flush, input logic ack, input logic [31:0] md,
                       input logic e_rdy, input logic e_val, input logic [31:0] e_data,
                       input logic e_mreq, input logic [31:0] e_maddr);
        vec_t v;
        v.rst = rst; v.req = req; v.addr = addr; v.flush = flush; v.ack = ack; v.mdata = md;
        v.e_rdy = e_rdy; v.e_val = e_val; v.e_data = e_data; v.e_mreq = e_mreq; v.e_maddr = e_maddr;
        vecs.push_back(v);
    endtask

    // One fetch from IDLE at a negedge; memory acks in the wait_cyc-th cycle of mem_req_out.
    task automatic fetch(input logic [31:0] a, input logic [31:0] md, input int wait_cyc,
                         output logic [31:0] d, output int lat);
        int w;
        bit ok;
        logic [31:0] exp_maddr;
        w = 0;
        ok = 0;
        d = '0;
        exp_maddr = {a[31:2], 2'b00};
        core_req_in  = 1'b1;
        core_addr_in = a;
        @(negedge clock_in);
        core_req_in = 1'b0;
        lat = 1;
        for (int i = 0; i < 40; i++) begin
            mem_ack_in = 1'b0;
            if (core_valid_out) begin
                ok = 1;
                d  = core_data_out;
                break;
            end
            if (mem_req_out) begin
                w++;
                chk("maddr_hold", mem_addr_out, exp_maddr);
                if (w >= wait_cyc) begin
                    mem_ack_in  = 1'b1;
                    mem_data_in = md;
                end
            end
            @(negedge clock_in);
            lat++;
        end
        mem_ack_in = 1'b0;
        chk("fetch_done", 32'(ok), 32'd1);
    endtask

    logic [31:0] d;
    int          lat;

    initial begin
        reset_in = 1'b1; core_req_in = 1'b0; core_addr_in = '0; core_flush_in = 1'b0;
        mem_data_in = '0; mem_ack_in = 1'b0;

        // rst req addr flush ack mdata | ready valid data mreq maddr
        add(0,1,32'h40,0,0,0,               1,0,0,0,0);
        add(0,0,0,0,0,0,                    0,0,0,1,32'h40);
        add(0,0,0,0,0,0,                    0,0,0,1,32'h40);
        add(0,0,0,0,1,32'h00500093,         0,0,0,1,32'h40);
        add(0,0,0,0,0,0,                    0,0,0,0,0);
        add(0,0,0,0,0,0,                    1,1,32'h00500093,0,0);
        add(0,1,32'h40,0,0,0,               1,0,0,0,0);
        add(0,1,32'h44,0,0,0,               1,1,32'h00500093,0,0);
        add(0,0,0,0,1,32'h00a00113,         0,0,0,1,32'h44);
        add(0,0,0,0,0,0,                    0,0,0,0,0);
        add(0,1,32'h40,0,0,0,               1,1,32'h00a00113,0,0);
        add(0,1,32'h44,0,0,0,               1,1,32'h00500093,0,0);
        add(0,0,0,0,0,0,                    1,1,32'h00a00113,0,0);
        add(0,0,0,0,1,32'hdeadbeef,         1,0,0,0,0);
        // conflict: 0x80 evicts 0x40
        add(0,1,32'h80,0,0,0,               1,0,0,0,0);
        add(0,0,0,0,1,32'h11111111,         0,0,0,1,32'h80);
        add(0,0,0,0,0,0,                    0,0,0,0,0);
        add(0,1,32'h40,0,0,0,               1,1,32'h11111111,0,0);
        add(0,0,0,0,1,32'h00500093,         0,0,0,1,32'h40);
        add(0,0,0,0,0,0,                    0,0,0,0,0);
        add(0,0,0,0,0,0,                    1,1,32'h00500093,0,0);
        // flush before ack, then flush coincident with ack
        add(0,1,32'h100,0,0,0,              1,0,0,0,0);
        add(0,0,0,1,0,0,                    0,0,0,1,32'h100);
        add(0,0,0,0,1,32'h22222222,         0,0,0,1,32'h100);
        add(0,0,0,0,0,0,                    0,0,0,0,0);
        add(0,1,32'h100,0,0,0,              1,1,32'h22222222,0,0);
        add(0,0,0,1,1,32'h33333333,         0,0,0,1,32'h100);
        add(0,0,0,0,0,0,                    0,0,0,0,0);
        add(0,1,32'h100,0,0,0,              1,1,32'h33333333,0,0);
        add(0,0,0,0,1,32'h44444444,         0,0,0,1,32'h100);
        add(0,0,0,0,0,0,                    0,0,0,0,0);
        add(0,1,32'h44,0,0,0,               1,1,32'h44444444,0,0);
        add(0,0,0,0,1,32'h00a00113,         0,0,0,1,32'h44);
        add(0,0,0,0,0,0,                    0,0,0,0,0);
        add(0,0,0,0,0,0,                    1,1,32'h00a00113,0,0);
        // flush with a request in IDLE: request refused, line invalidated
        add(0,1,32'h44,1,0,0,               0,0,0,0,0);
        add(0,1,32'h44,0,0,0,               1,0,0,0,0);
        add(0,0,0,0,1,32'h00a00113,         0,0,0,1,32'h44);
        add(0,0,0,0,0,0,                    0,0,0,0,0);
        add(0,1,32'h44,0,0,0,               1,1,32'h00a00113,0,0);
        // reset mid-refill, stray ack afterwards
        add(0,1,32'h200,0,0,0,              1,1,32'h00a00113,0,0);
        add(1,0,0,0,0,0,                    0,0,0,1,32'h200);
        add(0,0,0,0,1,32'h55555555,         1,0,0,0,0);
        add(0,1,32'h200,0,0,0,              1,0,0,0,0);
        add(0,0,0,0,1,32'h66666666,         0,0,0,1,32'h200);
        add(0,0,0,0,0,0,                    0,0,0,0,0);
        add(0,1,32'h44,0,0,0,               1,1,32'h66666666,0,0);
        add(0,0,0,0,1,32'h00a00113,         0,0,0,1,32'h44);
        add(0,0,0,0,0,0,                    0,0,0,0,0);
        // reset in IDLE with a request pending
        add(1,1,32'h200,0,0,0,              0,1,32'h00a00113,0,0);
        add(0,0,0,0,0,0,                    1,0,0,0,0);
        add(0,1,32'h200,0,0,0,              1,0,0,0,0);
        add(0,0,0,0,1,32'h66666666,         0,0,0,1,32'h200);
        add(0,0,0,0,0,0,                    0,0,0,0,0);
        add(0,0,0,0,0,0,                    1,1,32'h66666666,0,0);

        repeat (2) @(negedge clock_in);
        reset_in = 1'b0;
        #1;
        chk("rst_valid", 32'(core_valid_out), 32'd0);
        chk("rst_data",  core_data_out,       32'd0);
        chk("rst_mreq",  32'(mem_req_out),    32'd0);
        chk("rst_maddr", mem_addr_out,        32'd0);
        chk("rst_ready", 32'(core_ready_out), 32'd1);
        @(negedge clock_in);

        foreach (vecs[i]) begin
            reset_in      = vecs[i].rst;
            core_req_in   = vecs[i].req;
            core_addr_in  = vecs[i].addr;
            core_flush_in = vecs[i].flush;
            mem_ack_in    = vecs[i].ack;
            mem_data_in   = vecs[i].mdata;
            #1;
            chk($sformatf("v%0d ready", i), 32'(core_ready_out), 32'(vecs[i].e_rdy));
            chk($sformatf("v%0d valid", i), 32'(core_valid_out), 32'(vecs[i].e_val));
            chk($sformatf("v%0d mreq", i),  32'(mem_req_out),    32'(vecs[i].e_mreq));
            if (vecs[i].e_val)  chk($sformatf("v%0d data", i),  core_data_out, vecs[i].e_data);
            if (vecs[i].e_mreq) chk($sformatf("v%0d maddr", i), mem_addr_out,  vecs[i].e_maddr);
            @(negedge clock_in);
        end
        reset_in = 1'b0; core_req_in = 1'b0; core_addr_in = '0; core_flush_in = 1'b0;
        mem_ack_in = 1'b0; mem_data_in = '0;

        // slow memory: latency is 2 plus the ack wait
        fetch(32'h300, 32'hcafe0001, 6, d, lat);
        chk("slow_data", d, 32'hcafe0001);
        chk("slow_lat",  32'(lat), 32'd8);
        fetch(32'h303, 32'h0, 1, d, lat);
        chk("hit_data", d, 32'hcafe0001);
        chk("hit_lat",  32'(lat), 32'd1);
        @(negedge clock_in);
        chk("data_hold_valid", 32'(core_valid_out), 32'd0);
        chk("data_hold",       core_data_out,       32'hcafe0001);

`ifdef ICACHE_STATS_EN
        reset_in = 1'b1;
        @(negedge clock_in);
        reset_in = 1'b0;
        chk("stat_rst_hit",  hit_count_out,  32'd0);
        chk("stat_rst_miss", miss_count_out, 32'd0);
        fetch(32'h400, 32'ha0000001, 2, d, lat);
        fetch(32'h404, 32'ha0000002, 2, d, lat);
        fetch(32'h408, 32'ha0000003, 2, d, lat);
        fetch(32'h400, 32'h0, 1, d, lat);
        chk("stat_hit_data", d, 32'ha0000001);
        fetch(32'h400, 32'h0, 1, d, lat);
        fetch(32'h404, 32'h0, 1, d, lat);
        fetch(32'h408, 32'h0, 1, d, lat);
        fetch(32'h408, 32'h0, 1, d, lat);
        chk("stat_hit_lat", 32'(lat), 32'd1);
        chk("stat_hits",   hit_count_out,  32'd5);
        chk("stat_misses", miss_count_out, 32'd3);
        core_flush_in = 1'b1;
        @(negedge clock_in);
        core_flush_in = 1'b0;
        chk("stat_flush_hits",   hit_count_out,  32'd5);
        chk("stat_flush_misses", miss_count_out, 32'd3);
        reset_in = 1'b1;
        @(negedge clock_in);
        reset_in = 1'b0;
        chk("stat_rst2_hit",  hit_count_out,  32'd0);
        chk("stat_rst2_miss", miss_count_out, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
